// File: rtl/dht11_reader.sv
// DHT11 single-wire humidity/temperature reader: start pulse, response handshake, 40-bit capture.
// Define DHT11_CHECKSUM_EN to send checksum mismatches to ERRO; otherwise byte5 is discarded.
module dht11_reader #(
   parameter int CLK_FREQ_HZ      = 50000000,
   parameter int START_LOW_US     = 18000,
   parameter int BIT_THRESHOLD_US = 40,
   parameter int TIMEOUT_US       = 100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   inout  wire        dht11,
   output logic [7:0] umidadeInteira,
   output logic [7:0] umidadeDecimal,
   output logic [7:0] temperaturaInteira,
   output logic [7:0] temperaturaDecimal,
   output logic       dadosProntos,
   output logic       erro,
   output logic       ocupado
);

   // state       | meaning
   // IDLE        | line released, waiting for iniciar
   // START_LOW   | host holds line low for START_LOW_US
   // ESPERA_RESP | line released, waiting for sensor to pull low
   // RESP_LOW    | sensor response low phase
   // RESP_HIGH   | sensor response high phase
   // BIT_LOW     | low preamble of a data bit
   // BIT_HIGH    | high phase of a data bit, length decides 0/1
   // CHECK       | all 40 bits captured, checksum decision
   // DONE        | latch outputs, pulse dadosProntos
   // ERRO        | set sticky erro, outputs untouched
   localparam logic [3:0] S_IDLE        = 4'd0;
   localparam logic [3:0] S_START_LOW   = 4'd1;
   localparam logic [3:0] S_ESPERA_RESP = 4'd2;
   localparam logic [3:0] S_RESP_LOW    = 4'd3;
   localparam logic [3:0] S_RESP_HIGH   = 4'd4;
   localparam logic [3:0] S_BIT_LOW     = 4'd5;
   localparam logic [3:0] S_BIT_HIGH    = 4'd6;
   localparam logic [3:0] S_CHECK       = 4'd7;
   localparam logic [3:0] S_DONE        = 4'd8;
   localparam logic [3:0] S_ERRO        = 4'd9;

   localparam int TICK_DIV = (CLK_FREQ_HZ >= 2000000) ? (CLK_FREQ_HZ / 1000000) : 1;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LOAD   = PRE_W'(TICK_DIV - 1);
   localparam logic [14:0]      START_CNT  = 15'(START_LOW_US);
   localparam logic [14:0]      THRESH_CNT = 15'(BIT_THRESHOLD_US);
   localparam logic [14:0]      TOUT_CNT   = 15'(TIMEOUT_US);

   logic [3:0]       state;
   logic [3:0]       state_nx;
   logic [PRE_W-1:0] presc;
   logic             tick;
   logic [14:0]      phase_cnt;
   logic [1:0]       sync;
   logic             line_prev;
   logic             line_s;
   logic             fell;
   logic             rose;
   logic             timed_out;
   logic [5:0]       bit_cnt;
   logic             last_bit;
   logic [39:0]      shreg;

   // Only ever pull low; the external pull-up supplies the high level.
   assign dht11 = (state == S_START_LOW) ? 1'b0 : 1'bz;

   assign ocupado = (state != S_IDLE) && (state != S_DONE) && (state != S_ERRO);

   // Synchronizer resets high so the idle (pulled-up) line never looks like an edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync      <= 2'b11;
         line_prev <= 1'b1;
      end else begin
         sync      <= {sync[0], dht11};
         line_prev <= sync[1];
      end
   end

   assign line_s    = sync[1];
   assign fell      = line_prev & ~line_s;
   assign rose      = ~line_prev & line_s;
   assign tick      = (presc == '0);
   assign timed_out = (phase_cnt > TOUT_CNT);
   assign last_bit  = (bit_cnt == 6'd39);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) presc <= '0;
      else        presc <= tick ? PRE_LOAD : presc - PRE_W'(1);
   end

`ifdef DHT11_CHECKSUM_EN
   logic [7:0] checksum;
   assign checksum = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
`endif

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:        if (iniciar) state_nx = S_START_LOW;
         S_START_LOW:   if (phase_cnt >= START_CNT) state_nx = S_ESPERA_RESP;
         // Edge, not level: the synchronizer still shows our own drive for two cycles.
         S_ESPERA_RESP: if (fell) state_nx = S_RESP_LOW;
                        else if (timed_out) state_nx = S_ERRO;
         S_RESP_LOW:    if (rose) state_nx = S_RESP_HIGH;
                        else if (timed_out) state_nx = S_ERRO;
         S_RESP_HIGH:   if (fell) state_nx = S_BIT_LOW;
                        else if (timed_out) state_nx = S_ERRO;
         S_BIT_LOW:     if (rose) state_nx = S_BIT_HIGH;
                        else if (timed_out) state_nx = S_ERRO;
         S_BIT_HIGH:    if (fell) state_nx = last_bit ? S_CHECK : S_BIT_LOW;
                        else if (timed_out) state_nx = S_ERRO;
`ifdef DHT11_CHECKSUM_EN
         S_CHECK:       state_nx = (checksum == shreg[7:0]) ? S_DONE : S_ERRO;
`else
         S_CHECK:       state_nx = S_DONE;
`endif
         S_DONE:        state_nx = S_IDLE;
         S_ERRO:        state_nx = S_IDLE;
         default:       state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         phase_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state)                phase_cnt <= '0;
         else if (tick && (phase_cnt != '1))   phase_cnt <= phase_cnt + 15'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bit_cnt            <= '0;
         shreg              <= '0;
         umidadeInteira     <= '0;
         umidadeDecimal     <= '0;
         temperaturaInteira <= '0;
         temperaturaDecimal <= '0;
         dadosProntos       <= 1'b0;
         erro               <= 1'b0;
      end else begin
         dadosProntos <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iniciar) begin
                  erro    <= 1'b0;
                  bit_cnt <= '0;
                  shreg   <= '0;
               end
            end
            S_BIT_HIGH: begin
               // Falling edge ends the bit; phase_cnt holds its high time in microseconds.
               if (fell) begin
                  shreg   <= {shreg[38:0], (phase_cnt > THRESH_CNT)};
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            S_DONE: begin
               umidadeInteira     <= shreg[39:32];
               umidadeDecimal     <= shreg[31:24];
               temperaturaInteira <= shreg[23:16];
               temperaturaDecimal <= shreg[15:8];
               dadosProntos       <= 1'b1;
            end
            S_ERRO:  erro <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dht11_reader.md
DHT11_READER -- requirements
Module: dht11_reader

Interface
REQ-001 Parameter CLK_FREQ_HZ, 50000000, clock frequency used to derive all microsecond timings.
REQ-002 Parameter START_LOW_US, 18000, host start pulse low duration.
REQ-003 Parameter BIT_THRESHOLD_US, 40, high-phase length above which a bit is 1.
REQ-004 Parameter TIMEOUT_US, 100, maximum length of any sensor-driven phase.
REQ-005 Single clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  system clock, rising edge.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 iniciar  input  1  single-cycle request to start one measurement.
REQ-009 dht11  inout  1  open-drain data line: driven 0 or released to Z, never driven 1.
REQ-010 umidadeInteira, umidadeDecimal  output  8 each  humidity bytes 1 and 2.
REQ-011 temperaturaInteira, temperaturaDecimal  output  8 each  temperature bytes 3 and 4.
REQ-012 dadosProntos  output  1  one-cycle pulse when new valid data is latched.
REQ-013 erro  output  1  sticky flag: last measurement failed; cleared by the next accepted iniciar.
REQ-014 ocupado  output  1  high from accepted iniciar until DONE or ERRO.

Function
REQ-015 dht11 input passes through a 2-flop synchronizer; all edge decisions use the synchronized value; the extra latency is 2 cycles.
REQ-016 One free-running microsecond tick (a CLK_FREQ_HZ/1000000 prescaler) drives a 15-bit phase counter that is cleared on every state change.
REQ-017 States: IDLE, START_LOW, ESPERA_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, DONE, ERRO.
REQ-018 IDLE: line released; iniciar goes to START_LOW and clears erro; iniciar in any other state is ignored.
REQ-019 START_LOW: drive line 0 for START_LOW_US, then release and go to ESPERA_RESP.
REQ-020 ESPERA_RESP: synchronized line low goes to RESP_LOW; still high after TIMEOUT_US goes to ERRO.
REQ-021 RESP_LOW: on rising edge go to RESP_HIGH; RESP_HIGH: on falling edge go to BIT_LOW; TIMEOUT_US exceeded in either goes to ERRO.
REQ-022 BIT_LOW: on rising edge go to BIT_HIGH; BIT_HIGH: on falling edge shift in 1 if counter > BIT_THRESHOLD_US, else 0, MSB first, into a 40-bit shift register.
REQ-023 After the 40th bit go to CHECK; otherwise return to BIT_LOW; TIMEOUT_US exceeded in BIT_LOW or BIT_HIGH goes to ERRO.
REQ-024 The final falling edge ends bit 40; the sensor's trailing low pulse is not awaited.
REQ-025 CHECK: checksum is (byte1+byte2+byte3+byte4) mod 256 compared with byte5, computed as an 8-bit wrap-around sum.
REQ-026 DONE: latch the four data outputs, pulse dadosProntos for one cycle, return to IDLE.
REQ-027 ERRO: set erro, keep previous data outputs unchanged, no dadosProntos, return to IDLE.
REQ-028 An iniciar coincident with the DONE or ERRO cycle is ignored.

Reset
REQ-029 reset low immediately releases dht11 to Z, forces IDLE, and clears all data outputs, dadosProntos, erro, ocupado, counters, prescaler and shift register, including mid-transfer.
REQ-030 After reset deasserts, the first iniciar starts a full 18 ms start pulse.

Configuration
REQ-031 Macro DHT11_CHECKSUM_EN defined: a mismatch in CHECK goes to ERRO.
REQ-032 Macro DHT11_CHECKSUM_EN undefined: CHECK always goes to DONE and byte5 is discarded.

Verification
REQ-033 Sensor model replies with 0x37,0x00,0x19,0x00,0x50 -> outputs 0x37/0x00/0x19/0x00, one dadosProntos pulse, erro=0.
REQ-034 Same frame with byte5=0x51 -> with macro: erro=1, outputs unchanged; without macro: data latched.
REQ-035 No sensor response (line held high by pull-up) -> erro=1 about 100 us after release, ocupado falls.
REQ-036 Bit high phases of 26 us and 70 us -> decoded as 0 and 1 respectively; 40 us boundary decodes as 0.
REQ-037 reset pulsed low during bit 20 -> dht11 is Z in the same cycle, all outputs 0; a new iniciar then completes normally.
REQ-038 iniciar asserted repeatedly while ocupado=1 -> ignored; exactly one start pulse of 18000 us +/-1 us is observed.
